// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// -----------------------------------------------------------------------------
// Central stall/flush sequencer for the five-stage MiniMIPS32 pipeline.
//   * Merges the ID load-use stall request into the shared stall vector.
//   * Runs multi-cycle divides in EXE with an internal 6-bit down-counter.
//   * Turns a MEM-stage exception (or ERET) into a same-cycle pipeline flush.
//
// Parameters
//   DIV_CYCLES   : cycles a divide holds the pipeline (legal 2..63)
//
// Ports
//   cpu_clk_50M  in   clock, rising edge
//   cpu_rst_n    in   asynchronous active-low reset
//   stallreq_id  in   ID load-use hazard request
//   div_start    in   EXE holds a DIV/DIVU needing the divider
//   exc_valid    in   MEM stage reports an exception or ERET this cycle
//   stall[3:0]   out  bit0 PC, bit1 IF/ID, bit2 ID/EXE, bit3 EXE/MEM (1 = stop)
//   flush        out  clear all pipeline registers this cycle
//   div_busy     out  divider sequence in progress
//   div_done     out  divide result valid in EXE this cycle
//   div_abort    out  running divide cancelled by flush
//   stall_cycles out  count of cycles with stall[0] set
//
// Configuration macro
//   PIPE_STALL_PERF_EN : when defined, stall_cycles is a free-running 32-bit
//                        counter of stalled cycles; otherwise it is tied to 0.
//
// stall, flush, div_done and div_abort are decoded combinationally from the
// state, the counter and the inputs so that hazards act with zero latency.
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        stallreq_id,
  input  logic        div_start,
  input  logic        exc_valid,
  output logic [3:0]  stall,
  output logic        flush,
  output logic        div_busy,
  output logic        div_done,
  output logic        div_abort,
  output logic [31:0] stall_cycles
);

  typedef enum logic [0:0] {
    S_RUN      = 1'b0,
    S_DIV_WAIT = 1'b1
  } state_e;

  // Highest set bit loads a bubble, lower stages hold.
  localparam logic [3:0] STALL_NONE = 4'b0000;
  localparam logic [3:0] STALL_LOAD = 4'b0111;
  localparam logic [3:0] STALL_DIV  = 4'b1111;

  // Counter preload: the start cycle plus DIV_CYCLES-1 counted cycles give
  // exactly DIV_CYCLES stalled cycles before the done cycle.
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  // State and divide counter registers.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic; exceptions take priority over divides.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        if (exc_valid) begin
          state_d = S_RUN;
        end else if (div_start) begin
          state_d = S_DIV_WAIT;
          cnt_d   = DIV_LOAD;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DIV_WAIT: begin
        if (exc_valid) begin
          state_d = S_RUN;
          cnt_d   = 6'd0;
        end else if (cnt_q != 6'd0) begin
          cnt_d   = cnt_q - 6'd1;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // Output decode: stall vector, flush and divide status strobes.
  always_comb begin
    stall     = STALL_NONE;
    flush     = 1'b0;
    div_done  = 1'b0;
    div_abort = 1'b0;
    case (state_q)
      S_RUN: begin
        if (exc_valid) begin
          flush = 1'b1;
        end else if (div_start) begin
          stall = STALL_DIV;
        end else if (stallreq_id) begin
          stall = STALL_LOAD;
        end else begin
          stall = STALL_NONE;
        end
      end
      S_DIV_WAIT: begin
        // Load-use requests are subsumed by the full divide stall; div_start
        // is still high here but only matters in RUN.
        if (exc_valid) begin
          flush     = 1'b1;
          div_abort = 1'b1;
        end else if (cnt_q != 6'd0) begin
          stall = STALL_DIV;
        end else begin
          div_done = 1'b1;
        end
      end
      default: begin
        stall = STALL_NONE;
      end
    endcase
  end

  assign div_busy = (state_q == S_DIV_WAIT);

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] perf_q;

  // Stalled-cycle counter; flush cycles never have stall[0] set.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      perf_q <= 32'h0;
    end else if (stall[0]) begin
      perf_q <= perf_q + 32'd1;
    end else begin
      perf_q <= perf_q;
    end
  end

  assign stall_cycles = perf_q;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a table of single-cycle RUN vectors
// followed by hand-written divide, exception and reset sequences.
module tb_pipeline_ctrl;

  logic        cpu_clk_50M;
  logic        cpu_rst_n;
  logic        stallreq_id;
  logic        div_start;
  logic        exc_valid;
  logic [3:0]  stall;
  logic        flush;
  logic        div_busy;
  logic        div_done;
  logic        div_abort;
  logic [31:0] stall_cycles;

  int          n_cmp;
  int          n_bad;
  logic [31:0] exp_perf;

  pipeline_ctrl #(.DIV_CYCLES(32)) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst_n   (cpu_rst_n),
    .stallreq_id (stallreq_id),
    .div_start   (div_start),
    .exc_valid   (exc_valid),
    .stall       (stall),
    .flush       (flush),
    .div_busy    (div_busy),
    .div_done    (div_done),
    .div_abort   (div_abort),
    .stall_cycles(stall_cycles)
  );

  initial cpu_clk_50M = 1'b0;
  always #5 cpu_clk_50M = ~cpu_clk_50M;

  typedef struct {
    logic       sr;
    logic       ds;
    logic       ex;
    logic [3:0] st;
    logic       fl;
    logic       bu;
  } vec_t;

  vec_t tbl [10];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every output; stall_cycles reflects stalls of earlier cycles.
  task automatic check(input string tag, input logic [3:0] es, input logic ef,
                       input logic eb, input logic ed, input logic ea);
    cmp($sformatf("%s.stall", tag),     {28'h0, stall}, {28'h0, es});
    cmp($sformatf("%s.flush", tag),     {31'h0, flush}, {31'h0, ef});
    cmp($sformatf("%s.div_busy", tag),  {31'h0, div_busy}, {31'h0, eb});
    cmp($sformatf("%s.div_done", tag),  {31'h0, div_done}, {31'h0, ed});
    cmp($sformatf("%s.div_abort", tag), {31'h0, div_abort}, {31'h0, ea});
`ifdef PIPE_STALL_PERF_EN
    cmp($sformatf("%s.stall_cycles", tag), stall_cycles, exp_perf);
`else
    cmp($sformatf("%s.stall_cycles", tag), stall_cycles, 32'h0);
`endif
    if (es[0]) exp_perf = exp_perf + 32'd1;
  endtask

  // Drive one cycle's inputs shortly after the rising edge, then settle.
  task automatic cyc(input logic sr, input logic ds, input logic ex);
    @(posedge cpu_clk_50M);
    #2;
    stallreq_id = sr;
    div_start   = ds;
    exc_valid   = ex;
    #3;
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    exp_perf    = 32'h0;
    stallreq_id = 1'b0;
    div_start   = 1'b0;
    exc_valid   = 1'b0;
    cpu_rst_n   = 1'b1;
    #1 cpu_rst_n = 1'b0;

    //            sr    ds    ex    stall    flush bus
    tbl[0] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};

    // Reset held, inputs idle.
    #10;
    check("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge cpu_clk_50M);
    #2 cpu_rst_n = 1'b1;

    // Table-driven RUN-state vectors.
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].sr, tbl[i].ds, tbl[i].ex);
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].fl, tbl[i].bu, 1'b0, 1'b0);
    end

    // Divide with div_start held 33 cycles and a load-use request at t+5.
    for (int i = 0; i <= 32; i++) begin
      cyc((i == 5), 1'b1, 1'b0);
      check($sformatf("div_t%0d", i), (i < 32) ? 4'b1111 : 4'b0000,
            1'b0, (i > 0), (i == 32), 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    check("div_after", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Exception at t+10 of a divide.
    for (int i = 0; i <= 10; i++) begin
      cyc(1'b0, 1'b1, (i == 10));
      check($sformatf("exc_t%0d", i), (i < 10) ? 4'b1111 : 4'b0000,
            (i == 10), (i > 0), 1'b0, (i == 10));
    end
    for (int i = 0; i < 25; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      check($sformatf("exc_post%0d", i), 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Exception on the divide's final (cnt==0) cycle: flush beats done.
    for (int i = 0; i <= 32; i++) begin
      cyc(1'b0, 1'b1, (i == 32));
      check($sformatf("excz_t%0d", i), (i < 32) ? 4'b1111 : 4'b0000,
            (i == 32), (i > 0), 1'b0, (i == 32));
    end
    cyc(1'b0, 1'b0, 1'b0);
    check("excz_after", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Simultaneous exception, divide and load-use, then reset mid-divide.
    cyc(1'b1, 1'b1, 1'b1);
    check("all3", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      check($sformatf("rst_div%0d", i), 4'b1111, 1'b0, (i > 0), 1'b0, 1'b0);
    end
    @(posedge cpu_clk_50M);
    #2;
    cpu_rst_n   = 1'b0;
    div_start   = 1'b0;
    stallreq_id = 1'b0;
    exc_valid   = 1'b0;
    exp_perf    = 32'h0;
    #1;
    check("rst_mid", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge cpu_clk_50M);
    #2 cpu_rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      check($sformatf("rst_post%0d", i), 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage MiniMIPS32 pipeline. It collects the load-use stall request from ID, sequences multi-cycle divides in EXE with an internal cycle counter, and turns MEM-stage exceptions into a pipeline flush. It drives the shared `stall` vector and `flush` line consumed by the PC, IF/ID, ID/EXE and EXE/MEM registers.

## Interface
- `DIV_CYCLES`, 32, number of cycles a divide holds the pipeline (legal 2..63).
- `cpu_clk_50M` in 1: clock, rising edge.
- `cpu_rst_n` in 1: reset, asynchronous, active-low.
- `stallreq_id` in 1: ID load-use hazard request.
- `div_start` in 1: EXE holds a DIV/DIVU needing the divider.
- `exc_valid` in 1: MEM stage has `mem_exccode != EXC_NONE` (or ERET) this cycle.
- `stall` out 4: bit0 PC, bit1 IF/ID, bit2 ID/EXE, bit3 EXE/MEM; 1 = `STOP`.
- `flush` out 1: clear all pipeline registers this cycle.
- `div_busy` out 1: divider sequence in progress.
- `div_done` out 1: divide result valid in EXE this cycle.
- `div_abort` out 1: running divide cancelled by flush.
- `stall_cycles` out 32: stall cycle count (see Configuration).

## Operation
- States: RUN, DIV_WAIT. 6-bit down-counter `cnt`.
- Stall encoding: highest set bit's register loads a bubble, lower registers hold.
  - Load-use: `stall = 4'b0111` (PC, IF/ID hold; ID/EXE bubble).
  - Divide: `stall = 4'b1111` (EXE/MEM bubble).
  - None: `4'b0000`.
- Priority: `exc_valid` > divide > load-use.
- RUN:
  - `exc_valid`: `flush=1`, `stall=0`, stay RUN.
  - else `div_start`: `stall=4'b1111`, load `cnt=DIV_CYCLES-1`, go DIV_WAIT.
  - else `stallreq_id`: `stall=4'b0111`.
- DIV_WAIT:
  - `exc_valid`: `flush=1`, `stall=0`, `div_abort=1`, `cnt=0`, go RUN.
  - else `cnt!=0`: `stall=4'b1111`, decrement `cnt`; `stallreq_id` is subsumed.
  - else (`cnt==0`): `div_done=1`, `stall=0`, go RUN.
- `div_start` is honoured only in RUN. It stays high while EXE is held and is ignored in DIV_WAIT, including the done cycle.
- `div_busy = (state==DIV_WAIT)`.
- `stall`, `flush`, `div_done` and `div_abort` are combinational from state, `cnt` and inputs; there are no output registers.

## Timing
- Reset (asynchronous, any time, including mid-divide):
  - State RUN, `cnt=0`, `stall_cycles=0`.
  - All outputs 0 while inputs are idle.
  - An interrupted divide produces no `div_done` and no `div_abort`.
- Divide started at cycle t:
  - `stall=4'b1111` in cycles t..t+DIV_CYCLES-1, i.e. exactly DIV_CYCLES cycles.
  - `div_done=1` and `stall=0` in cycle t+DIV_CYCLES.
  - The next `div_start` can be accepted at t+DIV_CYCLES+1.
- Flush: same cycle as `exc_valid`; single-cycle unless `exc_valid` persists.
  - Flush and `div_start` together: flush wins and no divide starts.
- Load-use: zero latency. `stall` follows `stallreq_id` combinationally in RUN.
- `exc_valid` together with `cnt==0` in DIV_WAIT: flush wins, `div_abort=1`, `div_done=0`.

## Configuration
- `PIPE_STALL_PERF_EN` defined:
  - `stall_cycles` increments by 1 on every rising edge where `stall[0]==1`.
  - Wraps 0xFFFFFFFF→0; reset to 0.
  - Flush cycles are not counted.
- Not defined: `stall_cycles` is tied to 32'h0 and no counter is synthesised.

## Test plan
- Reset and idle (all inputs 0):
  - Required: `stall=0000`, `flush=0`, `div_busy=0`, `stall_cycles=0`.
  - Assert `cpu_rst_n=0` between clock edges → all state clears immediately.
- Load-use: `stallreq_id=1` for 2 cycles in RUN:
  - Required: `stall=0111` for exactly those 2 cycles, then `0000`.
  - With `PIPE_STALL_PERF_EN`: `stall_cycles=2`.
- Divide with DIV_CYCLES=32: `div_start` held high 33 cycles from t:
  - Required: `stall=1111` for t..t+31.
  - Required: `div_done=1` and `stall=0000` at t+32.
  - Required: no restart at t+32.
- Divide plus load-use: `stallreq_id=1` at t+5 during the divide:
  - Required: `stall` stays `1111`; the divide length is unchanged.
- Exception mid-divide: `exc_valid=1` at t+10:
  - Required: `flush=1`, `div_abort=1`, `stall=0000` that cycle.
  - Required: RUN next cycle, `div_busy=0`, no `div_done`.
- Simultaneous `exc_valid`, `div_start` and `stallreq_id` in RUN:
  - Required: `flush=1`, `stall=0000`, state stays RUN.
  - Then reset asserted mid-divide → no `div_done`, no `div_abort`.
